mem_access_unit: RTL

Load/store sequencer between the RV64 core's memory stage and the 32-bit byte-addressed simulation RAM.
- Accepts one load/store request per handshake and splits doubleword accesses into two 32-bit RAM transactions.
- Drives the RAM's mem_size/addr/data_i and captures its combinational data_o.
- Returns a sign- or zero-extended 64-bit result to the core.

---
 rtl/mem_access_pkg.sv | 45 ++++
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mem_access_unit_load_extend.sv | 25 ++
 rtl/mem_access_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: RV64 load/store funct3 values,
// RAM mem_size codes, the sequencer state type and the access legality check.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
  localparam logic [1:0] MEM_SIZE_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Unsupported encodings are folded into the misaligned outcome so the core
  // sees a single "not performed" response for both.
  function automatic logic access_rejected(logic we, logic [2:0] funct3, logic [2:0] addr_lo);
    logic bad_op;
    logic bad_align;
    bad_op = we ? funct3[2] : (funct3 == 3'b111);
    case (funct3[1:0])
      2'b01:   bad_align = addr_lo[0];
      2'b10:   bad_align = |addr_lo[1:0];
      2'b11:   bad_align = |addr_lo;
      default: bad_align = 1'b0;
    endcase
    return bad_op | bad_align;
  endfunction

  // SB/SH/SW map straight onto the RAM size code; SD goes out as two words.
  function automatic logic [1:0] store_size(logic [2:0] funct3);
    return (funct3[1:0] == F3_D[1:0]) ? MEM_SIZE_WORD : funct3[1:0];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the core memory stage and the unit, plus
// the 32-bit simulation RAM bus driven by the unit.
interface mem_access_unit_if #(parameter int RAM_AW = 32);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_misaligned;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [1:0]        ram_mem_size;
  logic [31:0]       ram_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           ram_addr, ram_wdata, ram_mem_size
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           ram_addr, ram_wdata, ram_mem_size
  );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of raw load data {hi, lo} according to the RV64 load funct3.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] raw,
  output logic [63:0] result
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
    result = '0;
    case (funct3)
      F3_B:    result = {{56{raw[7]}}, raw[7:0]};
      F3_H:    result = {{48{raw[15]}}, raw[15:0]};
      F3_W:    result = {{32{raw[31]}}, raw[31:0]};
      F3_D:    result = raw;
      F3_BU:   result = {56'd0, raw[7:0]};
      F3_HU:   result = {48'd0, raw[15:0]};
      F3_WU:   result = {32'd0, raw[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer from the RV64 memory stage onto a 32-bit byte-addressed RAM;
// doublewords are split into a low and a high word transaction.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RAM_AW = 32
) (
  input  logic              mem_clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);

  state_e            state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       wdata_hi_q;
  logic [31:0]       lo_q;
  logic [1:0]        size_q;
  logic [63:0]       raw_load;
  logic [63:0]       ext_load;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[63:RAM_AW];

  // The word arriving this cycle is folded in directly so the response can be
  // registered on the same edge that captures it.
  always_comb begin
    raw_load = {32'd0, bus.ram_rdata};
    if (state == ST_HI) raw_load = {bus.ram_rdata, lo_q};
  end

  load_extend u_load_extend (
    .funct3 (funct3_q),
    .raw    (raw_load),
    .result (ext_load)
  );

  assign bus.req_ready = (state == ST_IDLE);

  // Reset overrides the registered size so a reset cycle can never write the RAM.
  assign bus.ram_mem_size = reset ? MEM_SIZE_NONE : size_q;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      bus.resp_valid      <= 1'b0;
      bus.resp_rdata      <= '0;
      bus.resp_misaligned <= 1'b0;
      bus.ram_addr        <= '0;
      bus.ram_wdata       <= '0;
      size_q              <= MEM_SIZE_NONE;
      we_q                <= 1'b0;
      funct3_q            <= '0;
      addr_q              <= '0;
      wdata_hi_q          <= '0;
      lo_q                <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q       <= bus.req_we;
            funct3_q   <= bus.req_funct3;
            addr_q     <= bus.req_addr[RAM_AW-1:0];
            wdata_hi_q <= bus.req_wdata[63:32];
            if (access_rejected(bus.req_we, bus.req_funct3, bus.req_addr[2:0])) begin
              state               <= ST_RESP;
              bus.resp_valid      <= 1'b1;
              bus.resp_misaligned <= 1'b1;
              bus.resp_rdata      <= '0;
            end else begin
              state         <= ST_LO;
              bus.ram_addr  <= bus.req_addr[RAM_AW-1:0];
              bus.ram_wdata <= bus.req_wdata[31:0];
              size_q        <= bus.req_we ? store_size(bus.req_funct3) : MEM_SIZE_NONE;
            end
          end
        end

        ST_LO: begin
          if (!we_q) lo_q <= bus.ram_rdata;
          if (funct3_q[1:0] == F3_D[1:0]) begin
            state         <= ST_HI;
            bus.ram_addr  <= addr_q + RAM_AW'(4);
            bus.ram_wdata <= wdata_hi_q;
            size_q        <= we_q ? MEM_SIZE_WORD : MEM_SIZE_NONE;
          end else begin
            state          <= ST_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= we_q ? 64'd0 : ext_load;
            size_q         <= MEM_SIZE_NONE;
          end
        end

        ST_HI: begin
          state          <= ST_RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= we_q ? 64'd0 : ext_load;
          size_q         <= MEM_SIZE_NONE;
        end

        ST_RESP: begin
          state               <= ST_IDLE;
          bus.resp_valid      <= 1'b0;
          bus.resp_rdata      <= '0;
          bus.resp_misaligned <= 1'b0;
        end
      endcase
    end
  end

endmodule
